// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: clips a fill command to the visible area
// and streams one framebuffer write per pixel in raster order.
module rect_fill_engine #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x0,
  input  logic [9:0]        cmd_y0,
  input  logic [9:0]        cmd_w,
  input  logic [9:0]        cmd_h,
  input  logic [23:0]       cmd_color,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_data,
  input  logic              fb_grant,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    CLIP,
    DRAW,
    DONE
  } state_t;

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state;
  logic [9:0]        x0_q;
  logic [9:0]        y0_q;
  logic [9:0]        w_q;
  logic [9:0]        h_q;
  logic [23:0]       color_q;
  logic [10:0]       x_end;
  logic [10:0]       y_end;
  logic [10:0]       x;
  logic [10:0]       y;
  logic [ADDR_W-1:0] row_base;

  logic [10:0]       x_sum;
  logic [10:0]       y_sum;
  logic [10:0]       x_lim;
  logic [10:0]       y_lim;
  logic              empty;
  logic [ADDR_W-1:0] base0;
  logic [ADDR_W-1:0] next_row;
  logic              x_last;
  logic              y_last;

  // Clip window from the latched command; 11-bit sums cannot wrap
  always_comb begin
    x_sum = {1'b0, x0_q} + {1'b0, w_q};
    y_sum = {1'b0, y0_q} + {1'b0, h_q};
    x_lim = (x_sum > H_LIM) ? H_LIM : x_sum;
    y_lim = (y_sum > V_LIM) ? V_LIM : y_sum;
    empty = (w_q == 10'd0)
         || (h_q == 10'd0)
         || ({1'b0, x0_q} >= H_LIM)
         || ({1'b0, y0_q} >= V_LIM);
    base0 = ADDR_W'(y0_q) * H_STEP;
  end

  // Raster position flags and add-only next-row address
  always_comb begin
    x_last   = (x + 11'd1) == x_end;
    y_last   = (y + 11'd1) == y_end;
    next_row = row_base + H_STEP;
  end

  // Control FSM with registered handshake and write outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      x_end     <= '0;
      y_end     <= '0;
      x         <= '0;
      y         <= '0;
      row_base  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            x0_q      <= cmd_x0;
            y0_q      <= cmd_y0;
            w_q       <= cmd_w;
            h_q       <= cmd_h;
            color_q   <= cmd_color;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= CLIP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        CLIP: begin
          x_end <= x_lim;
          y_end <= y_lim;
          if (empty) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            x        <= {1'b0, x0_q};
            y        <= {1'b0, y0_q};
            row_base <= base0;
            fb_addr  <= base0 + ADDR_W'(x0_q);
            fb_data  <= color_q;
            fb_we    <= 1'b1;
            state    <= DRAW;
          end
        end
        DRAW: begin
          // Without a grant every write output simply holds
          if (fb_grant) begin
            if (x_last) begin
              if (y_last) begin
                fb_we <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                x        <= {1'b0, x0_q};
                y        <= y + 11'd1;
                row_base <= next_row;
                fb_addr  <= next_row + ADDR_W'(x0_q);
              end
            end else begin
              x       <= x + 11'd1;
              fb_addr <= fb_addr + ONE;
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Randomized bench for rect_fill_engine against a
// pixel-list reference model of the clipped rectangle.
module tb_rect_fill_engine;

  localparam int HR = 640;
  localparam int VR = 480;
  localparam int LIMIT = 6000;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x0;
  logic [9:0]  cmd_y0;
  logic [9:0]  cmd_w;
  logic [9:0]  cmd_h;
  logic [23:0] cmd_color;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [23:0] fb_data;
  logic        fb_grant;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  rect_fill_engine #(
    .H_RES(HR),
    .V_RES(VR),
    .ADDR_W(19)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0),
    .cmd_y0(cmd_y0),
    .cmd_w(cmd_w),
    .cmd_h(cmd_h),
    .cmd_color(cmd_color),
    .fb_we(fb_we),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .fb_grant(fb_grant),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: every visible pixel of the rectangle, raster order
  function automatic void ref_pixels(input int x0, input int y0,
                                     input int w, input int h,
                                     ref int q[$]);
    q.delete();
    for (int yy = y0; yy < y0 + h && yy < VR; yy++)
      for (int xx = x0; xx < x0 + w && xx < HR; xx++)
        q.push_back(yy * HR + xx);
  endfunction

  // Present a command and wait (bounded) for its acceptance edge;
  // afterwards load the follow-up command, if any, onto the bus
  task automatic accept(input int x0, input int y0, input int w,
                        input int h, input logic [23:0] col,
                        input bit nxt, input int nx0, input int ny0,
                        input int nw, input int nh,
                        input logic [23:0] ncol, output int waited);
    cmd_x0    = 10'(x0);
    cmd_y0    = 10'(y0);
    cmd_w     = 10'(w);
    cmd_h     = 10'(h);
    cmd_color = col;
    cmd_valid = 1'b1;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= LIMIT) begin
      $display("FAIL accept_timeout got %0d expected <%0d", waited, LIMIT);
      errors++;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $fatal(1, "accept timeout");
    end
    @(posedge clk);
    #1;
    cmd_valid = nxt;
    cmd_x0    = 10'(nx0);
    cmd_y0    = 10'(ny0);
    cmd_w     = 10'(nw);
    cmd_h     = 10'(nh);
    cmd_color = ncol;
  endtask

  // Follow one accepted command through to done; stall_pct < 0
  // means: withhold the grant for two cycles on the second write
  task automatic track(input int x0, input int y0, input int w,
                       input int h, input logic [23:0] col,
                       input int stall_pct);
    int q[$];
    int n;
    int stalls;
    int done_cyc;
    bit held;
    logic [18:0] ha;
    logic [23:0] hd;
    ref_pixels(x0, y0, w, h, q);
    n = 0;
    stalls = 0;
    done_cyc = -1;
    held = 0;
    ha = '0;
    hd = '0;
    for (int cyc = 1; cyc < LIMIT; cyc++) begin
      @(negedge clk);
      if (held) begin
        chk("hold_we", 64'(fb_we), 64'd1);
        chk("hold_addr", 64'(fb_addr), 64'(ha));
        chk("hold_data", 64'(fb_data), 64'(hd));
        held = 0;
      end
      chk("busy_run", 64'(busy), 64'd1);
      chk("ready_run", 64'(cmd_ready), 64'd0);
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (stall_pct < 0)
        fb_grant = !(fb_we === 1'b1 && n == 1 && stalls < 2);
      else
        fb_grant = ($urandom_range(99) >= stall_pct);
      if (fb_we === 1'b1) begin
        if (fb_grant) begin
          if (n < q.size()) begin
            chk("wr_addr", 64'(fb_addr), 64'(q[n]));
            chk("wr_data", 64'(fb_data), 64'(col));
          end else begin
            chk("extra_write", 64'(n), 64'(q.size()));
          end
          n++;
        end else begin
          stalls++;
          held = 1;
          ha = fb_addr;
          hd = fb_data;
        end
      end
    end
    fb_grant = 1'b1;
    chk("write_count", 64'(n), 64'(q.size()));
    chk("done_cycle", 64'(done_cyc),
        64'((q.size() == 0) ? 2 : 2 + q.size() + stalls));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("ready_after", 64'(cmd_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic run(input int x0, input int y0, input int w,
                     input int h, input logic [23:0] col,
                     input int stall_pct);
    int waited;
    accept(x0, y0, w, h, col, 1'b0, 0, 0, 0, 0, 24'h0, waited);
    track(x0, y0, w, h, col, stall_pct);
  endtask

  initial begin
    int waited;
    int nw;
    int px;
    int py;
    int pw;
    int ph;
    logic [23:0] pc;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_x0    = '0;
    cmd_y0    = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;
    fb_grant  = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_we", 64'(fb_we), 64'd0);
    chk("rst_addr", 64'(fb_addr), 64'd0);
    chk("rst_data", 64'(fb_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_post_rst", 64'(cmd_ready), 64'd1);

    run(0, 0, 2, 2, 24'hFF0000, 0);
    run(638, 478, 4, 4, 24'h00FF00, 0);
    run(10, 0, 3, 1, 24'h0000FF, -1);
    run(0, 0, 0, 5, 24'h123456, 0);
    run(700, 0, 5, 5, 24'h123456, 0);
    run(0, 480, 5, 5, 24'h123456, 0);
    run(5, 7, 3, 0, 24'h654321, 30);

    // second command waits on the bus while the first one runs
    accept(20, 30, 5, 3, 24'hABCDEF, 1'b1, 630, 100, 20, 2,
           24'h13579B, waited);
    track(20, 30, 5, 3, 24'hABCDEF, 25);
    accept(630, 100, 20, 2, 24'h13579B, 1'b0, 0, 0, 0, 0,
           24'h0, waited);
    chk("b2b_accept_wait", 64'(waited), 64'd0);
    track(630, 100, 20, 2, 24'h13579B, 0);

    for (int i = 0; i < 25; i++) begin
      px = $urandom_range(700);
      py = $urandom_range(520);
      pw = $urandom_range(30);
      ph = $urandom_range(12);
      pc = 24'($urandom);
      run(px, py, pw, ph, pc, $urandom_range(40));
    end

    // reset in the middle of a long row
    accept(0, 0, 100, 1, 24'hFFFFFF, 1'b0, 0, 0, 0, 0, 24'h0,
           waited);
    nw = 0;
    for (int cyc = 0; cyc < 50 && nw < 5; cyc++) begin
      @(negedge clk);
      fb_grant = 1'b1;
      if (fb_we === 1'b1) begin
        chk("mid_addr", 64'(fb_addr), 64'(nw));
        nw++;
      end
    end
    chk("mid_writes", 64'(nw), 64'd5);
    @(negedge clk);
    chk("mid_still_we", 64'(fb_we), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we", 64'(fb_we), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_ready", 64'(cmd_ready), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_post", 64'(cmd_ready), 64'd1);
    chk("abort_no_done", 64'(done), 64'd0);
    chk("abort_no_we", 64'(fb_we), 64'd0);

    run(3, 2, 4, 2, 24'h0F0F0F, 10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Hardware drawing engine that fills an axis-aligned rectangle in the framebuffer with a single 24-bit colour. It sits directly upstream of the VGA output stage. The CPU issues a fill command; this block generates the framebuffer write stream that the VGA module later scans out as R/G/B. Rectangles are clipped to the visible area, and writes stall under framebuffer arbitration.

## Interface
Parameters:
- H_RES, 640, visible pixels per line
- V_RES, 480, visible lines per frame
- ADDR_W, 19, framebuffer word address width (must satisfy H_RES*V_RES ≤ 2^ADDR_W)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x0  in  10  left column
- cmd_y0  in  10  top row
- cmd_w  in  10  width in pixels
- cmd_h  in  10  height in lines
- cmd_color  in  24  fill colour {R[7:0],G[7:0],B[7:0]}
- fb_we  out  1  write request
- fb_addr  out  ADDR_W  pixel address = y*H_RES + x
- fb_data  out  24  pixel colour
- fb_grant  in  1  framebuffer accepts the write this cycle
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CLIP, DRAW, DONE.
- IDLE:
  - cmd_ready=1.
  - A command is accepted when cmd_valid && cmd_ready; all cmd_* fields are registered and the FSM goes to CLIP.
- CLIP (exactly one cycle):
  - x_end = min(x0+w, H_RES) and y_end = min(y0+h, V_RES), computed at 11 bits (no wrap).
  - If w==0, h==0, x0≥H_RES or y0≥V_RES, go to DONE with no writes.
  - Otherwise load x=x0, y=y0, row_base=y0*H_RES and go to DRAW.
- DRAW:
  - fb_we=1, fb_addr=row_base+x, fb_data=colour.
  - A write completes on a cycle with fb_we && fb_grant; only then does the engine advance.
  - Advance order is x first; at x_end-1 it wraps to x0, y increments and row_base += H_RES.
  - After the write at (x_end-1, y_end-1) completes, go to DONE.
- While fb_grant=0, fb_we, fb_addr and fb_data hold stable.
- DONE (one cycle): done=1, then IDLE.
- busy=1 in CLIP, DRAW and DONE; 0 in IDLE.
- cmd_ready=0 in every state except IDLE. Commands presented while busy are not accepted and are not lost: they are taken when IDLE is reached.
- Pixel write count = (x_end-x0)*(y_end-y0), writes in raster order. No pixel outside [0,H_RES)×[0,V_RES) is ever written.
- Multiplication y0*H_RES happens only in CLIP. DRAW uses add-only address update.

## Timing
- Reset (rst=1 at a clock edge):
  - Next state is IDLE.
  - fb_we=0, fb_addr=0, fb_data=0, busy=0, done=0, cmd_ready=0 while rst is high.
  - cmd_ready=1 on the first cycle after rst deasserts.
- Reset mid-DRAW aborts immediately: fb_we falls on the next edge, no done pulse, and the partial rectangle stays in memory.
- Command accepted at edge N:
  - CLIP during cycle N+1.
  - First fb_we=1 during cycle N+2.
- With fb_grant held at 1:
  - One write per cycle, last write in cycle N+1+W*H (W, H clipped).
  - done=1 in cycle N+2+W*H; cmd_ready=1 in cycle N+3+W*H.
- Each cycle of fb_grant=0 during DRAW adds exactly one cycle of latency.
- Degenerate or fully clipped command: done=1 in cycle N+2, zero writes.
- Outputs fb_we, fb_addr, fb_data, done, busy and cmd_ready are registered or derived only from state registers. There is no combinational path from cmd_* or fb_grant to any output.

## Test plan
- Basic fill:
  - Stimulus: reset, then cmd (x0=0, y0=0, w=2, h=2, colour 0xFF0000), fb_grant=1.
  - Response: 4 writes, addresses 0, 1, 640, 641, all data 0xFF0000; done exactly one cycle, at accept+6.
- Corner clip:
  - Stimulus: cmd (638, 478, w=4, h=4).
  - Response: exactly 4 writes, addresses 306558, 306559, 307198, 307199; done pulses once.
- Arbitration stall:
  - Stimulus: cmd (10, 0, w=3, h=1); drop fb_grant for 2 cycles on the second write.
  - Response: fb_addr stays 11 with fb_we=1 while grant is 0; writes 10, 11, 12 each exactly once; done at accept+7.
- Degenerate commands:
  - Stimulus: w=0; then x0=700; then y0=480.
  - Response: each gives zero fb_we cycles and done at accept+2; cmd_ready returns the following cycle.
- Reset mid-draw:
  - Stimulus: cmd (0, 0, w=100, h=1); assert rst after 5 writes.
  - Response: fb_we=0 on the next edge, no done pulse, cmd_ready=1 on the cycle after rst releases.
- Back-to-back commands:
  - Stimulus: hold cmd_valid with a second command while busy.
  - Response: the second command is accepted in the first IDLE cycle after done, and its write sequence is correct.
